// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU, one quotient bit per cycle.
// Optional DIV_FAST_ZERO_EN: a zero dividend skips the iteration loop.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    state_e             state_q, state_d;
    logic [2*WIDTH:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               sgn_q, sgn_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               go;
    logic               zero_path;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo, rem, quo_f, rem_f;

    assign go = start_i && !annul_i;

`ifdef DIV_FAST_ZERO_EN
    assign zero_path = (opdata2_i == '0) || (opdata1_i == '0);
`else
    assign zero_path = (opdata2_i == '0);
`endif

    assign neg_a = signed_div_i && opdata1_i[WIDTH-1];
    assign neg_b = signed_div_i && opdata2_i[WIDTH-1];
    assign mag_a = neg_a ? ('0 - opdata1_i) : opdata1_i;
    assign mag_b = neg_b ? ('0 - opdata2_i) : opdata2_i;

    // Trial subtract on the partial remainder; bit WIDTH is the borrow.
    assign trial = {1'b0, work_q[2*WIDTH-1:WIDTH]} - {1'b0, dvsr_q};

    assign quo   = work_q[WIDTH-1:0];
    assign rem   = work_q[2*WIDTH:WIDTH+1];
    assign quo_f = (sgn_q && (neg_a_q ^ neg_b_q)) ? ('0 - quo) : quo;
    assign rem_f = (sgn_q && neg_a_q) ? ('0 - rem) : rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            work_q   <= '0;
            cnt_q    <= '0;
            dvsr_q   <= '0;
            sgn_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            dvsr_q   <= dvsr_d;
            sgn_q    <= sgn_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FREE: begin
                if (go) begin
                    state_d = zero_path ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: state_d = S_END;
            S_ON: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_d = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    always_comb begin
        work_d   = work_q;
        cnt_d    = cnt_q;
        dvsr_d   = dvsr_q;
        sgn_d    = sgn_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = '0;
        ready_d  = 1'b0;
        unique case (state_q)
            S_FREE: begin
                if (go) begin
                    work_d  = {{WIDTH{1'b0}}, mag_a, 1'b0};
                    cnt_d   = '0;
                    dvsr_d  = mag_b;
                    sgn_d   = signed_div_i;
                    neg_a_d = neg_a;
                    neg_b_d = neg_b;
                end
            end
            S_BYZERO: work_d = '0;
            S_ON: begin
                if (annul_i) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    if (trial[WIDTH]) begin
                        work_d = {work_q[2*WIDTH-1:0], 1'b0};
                    end else begin
                        work_d = {trial[WIDTH-1:0],
                                  work_q[WIDTH-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    work_d = {rem_f, work_q[WIDTH], quo_f};
                    cnt_d  = '0;
                end
            end
            S_END: begin
                if (start_i) begin
                    result_d = {rem, quo};
                    ready_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: results, latency, hold,
// release, annul and reset corner cases.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[12];

`ifdef DIV_FAST_ZERO_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 34;
`endif

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Start an op; returns edges after E until ready_o (99 = none).
    task automatic do_op(input logic s,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output int lat);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        lat = 99;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v,
                           input int hold,
                           input string nm);
        int lat;
        do_op(v.sgn, v.a, v.b, lat);
        chk({nm, " latency"}, 64'(lat), 64'(v.lat));
        chk({nm, " result"}, result_o, v.res);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({nm, " hold ready"}, 64'(ready_o), 64'd1);
            chk({nm, " hold result"}, result_o, v.res);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, " release ready"}, 64'(ready_o), 64'd0);
        chk({nm, " release result"}, result_o, 64'd0);
    endtask

    task automatic no_ready(input string nm);
        int seen;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        chk(nm, 64'(seen), 64'd0);
    endtask

    initial begin
        vec_t v93;
        int   lat;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        vecs[0]  = '{1'b0, 32'd100, 32'd7,
                     64'h00000002_0000000E, 34};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,
                     64'hFFFFFFFF_FFFFFFFD, 34};
        vecs[2]  = '{1'b1, 32'd7, 32'hFFFFFFFE,
                     64'h00000001_FFFFFFFD, 34};
        vecs[3]  = '{1'b0, 32'hFFFFFFFF, 32'd1,
                     64'h00000000_FFFFFFFF, 34};
        vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
                     64'h00000000_80000000, 34};
        vecs[5]  = '{1'b0, 32'd5, 32'd0, 64'd0, 2};
        vecs[6]  = '{1'b1, 32'hFFFFFFF9, 32'd0, 64'd0, 2};
        vecs[7]  = '{1'b0, 32'd0, 32'd5, 64'd0, ZLAT};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'hC0000000,
                     64'h3FFFFFFF_00000001, 34};
        vecs[9]  = '{1'b1, 32'd100, 32'hFFFFFFF9,
                     64'h00000002_FFFFFFF2, 34};
        vecs[10] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
                     64'hFFFFFFFE_0000000E, 34};
        vecs[11] = '{1'b0, 32'hFFFFFFF9, 32'd2,
                     64'h00000001_7FFFFFFC, 34};
        v93 = '{1'b0, 32'd9, 32'd3, 64'd3, 34};

        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], (i == 0) ? 5 : 1,
                    $sformatf("vec%0d", i));
        end

        // Flush during the iteration loop.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        no_ready("annul no ready");
        run_vec(v93, 1, "after annul");

        // Start together with annul in FREE is ignored.
        @(negedge clk);
        start_i = 1'b1;
        annul_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        no_ready("start+annul ignored");

        // Annul has no effect once the result is out.
        do_op(1'b0, 32'd9, 32'd3, lat);
        chk("end latency", 64'(lat), 64'd34);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        chk("end annul ready", 64'(ready_o), 64'd1);
        chk("end annul result", result_o, 64'd3);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("end annul release", 64'(ready_o), 64'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midop rst ready", 64'(ready_o), 64'd0);
        chk("midop rst result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        no_ready("midop rst no ready");
        run_vec(v93, 1, "after rst");

        // Reset while the result is being presented.
        do_op(1'b0, 32'd100, 32'd7, lat);
        chk("rst end latency", 64'(lat), 64'd34);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("end rst ready", 64'(ready_o), 64'd0);
        chk("end rst result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle integer divider and its sequencing FSM, used by the EX stage for DIV/DIVU.
- EX starts an operation, holds its operands and stalls the pipeline until this block returns {remainder, quotient}.
- EX then writes the result to HI/LO.
- Restoring shift-subtract datapath: one quotient bit per cycle, MSB first.

Parameters:
- WIDTH, 32, operand width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled only with start
- opdata1_i  in  WIDTH  dividend; EX holds it stable while start_i=1
- opdata2_i  in  WIDTH  divisor; EX holds it stable while start_i=1
- start_i  in  1  request; held high by EX until ready_o is seen
- annul_i  in  1  abort the current operation (pipeline flush)
- result_o  out  2*WIDTH  {remainder[63:32], quotient[31:0]}; registered
- ready_o  out  1  result valid; registered

Behaviour:
- rst=1 at a clock edge:
  - state -> FREE; result_o=0, ready_o=0, counter=0.
  - Overrides every other input, including mid-operation.
- States: FREE, BYZERO, ON, END. Edge E is the edge where FREE samples start_i=1 and annul_i=0.
- FREE:
  - ready_o=0, result_o=0.
  - start_i=1 and annul_i=1 together: start is ignored, state stays FREE.
  - start_i=1, divisor==0: go to BYZERO.
  - Otherwise: go to ON with counter=0. The 65-bit working register is loaded with {32'b0, |dividend|, 1'b0}.
    - Signed: magnitudes are the two's-complement negation of negative operands.
    - Unsigned: raw operands are used.
  - Divisor magnitude and signs are latched at E.
- BYZERO: working register cleared; next edge -> END.
- ON:
  - annul_i=1: go to FREE, counter=0, no ready pulse.
  - counter<32, one step per cycle:
    - trial = upper 32 bits − |divisor| (33-bit subtract).
    - If trial is negative: shift the working register left, inserting 0.
    - Else: replace the upper part with trial[31:0], shift left, inserting 1.
    - counter increments.
  - counter==32, one final cycle:
    - Signed op with operand signs differing: quotient is negated.
    - Signed op with negative dividend: remainder is negated (remainder takes the dividend's sign).
    - Then go to END, counter=0.
- END:
  - result_o <= final {rem, quo}; ready_o <= 1.
  - While start_i=1: stays in END; ready_o=1 and result_o held constant.
  - start_i=0: go to FREE; ready_o=0 and result_o=0 at that edge.
  - annul_i is ignored in END; EX drops start_i on a flush.
- Latency:
  - Normal operation: ready_o=1 visible after edge E+34 (E+1..E+32 steps, E+33 sign fix, E+34 END output).
  - Divide by zero: ready_o=1 after edge E+2.
- Arithmetic:
  - Truncating division toward zero.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0; no trap.
- Divide by zero: result_o=0, no exception raised here.

Optional Feature:
- Macro DIV_FAST_ZERO_EN.
- Defined: in FREE, dividend==0 with a nonzero divisor takes the BYZERO path. result_o=0 and ready_o=1 after E+2.
- Undefined: a zero dividend runs the full 32-step sequence. Result is still 0, with ready after E+34.

Test Plan:
- Unsigned 100/7, start held -> ready_o rises after E+34; result_o = 0x00000002_0000000E; ready_o stays 1 while start stays high for 5 more cycles.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002) -> result_o = 0xFFFFFFFF_FFFFFFFD; signed 7/−2 -> 0x00000001_FFFFFFFD.
- Unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF. Signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
- Divisor 0 (any dividend) -> ready_o after E+2 with result_o = 0. Drop start_i -> next edge ready_o=0, result_o=0, state FREE.
- annul_i=1 at E+10 -> no ready_o pulse, state FREE at E+11. Then 9/3 -> 0x00000000_00000003 after a further 34 edges. rst=1 at E+20 of another op -> all outputs 0 after that edge.
- 0/5: with DIV_FAST_ZERO_EN, ready_o after E+2; without it, after E+34; result_o=0 in both cases.
